// File: rtl/cnn_defs.sv
// Shared CNN accelerator definitions: datapath widths, layer-controller phase
// encodings and small helpers used by the sequencing logic.
package cnn_defs;

    localparam int CH_W   = 8;
    localparam int ADDR_W = 16;
    localparam int POOL_W = 16;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_LOAD = 3'd1,
        PH_CONV = 3'd2,
        PH_TREE = 3'd3,
        PH_COUT = 3'd4,
        PH_POOL = 3'd5
    } phase_e;

    // True when two or more of the phase command strobes are raised together.
    function automatic logic multi_hot(input logic [4:0] cmds);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + 32'(cmds[i]);
        end
        return ones > 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after its terminal value; a clear or a
// load-to-zero takes priority over an increment.
module wrap_counter #(
    parameter int          W    = 8,
    parameter int unsigned TERM = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         load0,
    output logic [W-1:0] cnt,
    output logic         at_last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_last = (cnt_q == W'(TERM));
    assign cnt     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || load0) begin
            cnt_d = '0;
        end else if (cnt_q > W'(TERM)) begin
            // Unreachable in normal operation; pulls a corrupted count back into range.
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Tracks input/output channel and pool progress through one CNN layer,
// issues channel-memory reads and flags protocol violations.
module layer_sequencer
    import cnn_defs::*;
#(
    parameter int IC_NUM   = 4,
    parameter int OC_NUM   = 8,
    parameter int POOL_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               c_load,
    input  logic               conv,
    input  logic               tree,
    input  logic               cout,
    input  logic               pool,
    output logic               conv_done,
    output logic               cout_done,
    output logic               pool_done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [CH_W-1:0]    ic_idx,
    output logic [CH_W-1:0]    oc_idx,
    output logic               layer_done,
    output logic               err
);

    logic [CH_W-1:0]   ic_cnt;
    logic [CH_W-1:0]   oc_cnt;
    logic [POOL_W-1:0] pool_cnt;
    logic              ic_last;
    logic              oc_last;
    logic              pool_last;
    logic              step;

    logic              rd_en_q,      rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
    logic              layer_done_q, layer_done_d;
    logic              err_q,        err_d;

    // With a single input channel there is no adder tree, so conv advances the channel.
    assign step = (IC_NUM > 1) ? tree : conv;

    wrap_counter #(.W(CH_W), .TERM(IC_NUM - 1)) u_ic_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .inc     (step),
        .load0   (c_load),
        .cnt     (ic_cnt),
        .at_last (ic_last)
    );

    wrap_counter #(.W(CH_W), .TERM(OC_NUM - 1)) u_oc_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .inc     (cout),
        .load0   (1'b0),
        .cnt     (oc_cnt),
        .at_last (oc_last)
    );

    wrap_counter #(.W(POOL_W), .TERM(POOL_LEN - 1)) u_pool_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .inc     (pool),
        .load0   (1'b0),
        .cnt     (pool_cnt),
        .at_last (pool_last)
    );

    assign conv_done = (conv || tree) && ic_last;
    assign cout_done = cout && oc_last;
    assign pool_done = pool && pool_last;

    always_comb begin
        rd_en_d      = conv;
        rd_addr_d    = rd_addr_q;
        layer_done_d = pool_done;
        err_d        = err_q;

        if (conv) begin
            // Modulo-2^16 product equals the full-width product truncated to 16 bits.
            rd_addr_d = ADDR_W'(oc_cnt) * ADDR_W'(IC_NUM) + ADDR_W'(ic_cnt);
        end

        if (multi_hot({c_load, conv, tree, cout, pool})
            || (cout && (ic_cnt != '0))
            || (pool && (oc_cnt != '0))) begin
            err_d = 1'b1;
        end

        if (clr) begin
            rd_en_d      = 1'b0;
            rd_addr_d    = '0;
            layer_done_d = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            layer_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            layer_done_q <= layer_done_d;
            err_q        <= err_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign layer_done = layer_done_q;
    assign err        = err_q;
    assign ic_idx     = ic_cnt;
    assign oc_idx     = oc_cnt;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: a 4x2 layer with a 3-cycle pool phase, plus a single-input-channel
// instance driven by the same command stream.
module tb_layer_sequencer;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic clr    = 1'b0;
    logic c_load = 1'b0;
    logic conv   = 1'b0;
    logic tree   = 1'b0;
    logic cout   = 1'b0;
    logic pool   = 1'b0;

    logic        a_conv_done, a_cout_done, a_pool_done, a_rd_en, a_layer_done, a_err;
    logic [15:0] a_rd_addr;
    logic [7:0]  a_ic_idx, a_oc_idx;

    logic        b_conv_done, b_cout_done, b_pool_done, b_rd_en, b_layer_done, b_err;
    logic [15:0] b_rd_addr;
    logic [7:0]  b_ic_idx, b_oc_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.IC_NUM(4), .OC_NUM(2), .POOL_LEN(3)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .c_load     (c_load),
        .conv       (conv),
        .tree       (tree),
        .cout       (cout),
        .pool       (pool),
        .conv_done  (a_conv_done),
        .cout_done  (a_cout_done),
        .pool_done  (a_pool_done),
        .rd_en      (a_rd_en),
        .rd_addr    (a_rd_addr),
        .ic_idx     (a_ic_idx),
        .oc_idx     (a_oc_idx),
        .layer_done (a_layer_done),
        .err        (a_err)
    );

    layer_sequencer #(.IC_NUM(1), .OC_NUM(2), .POOL_LEN(3)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .c_load     (c_load),
        .conv       (conv),
        .tree       (tree),
        .cout       (cout),
        .pool       (pool),
        .conv_done  (b_conv_done),
        .cout_done  (b_cout_done),
        .pool_done  (b_pool_done),
        .rd_en      (b_rd_en),
        .rd_addr    (b_rd_addr),
        .ic_idx     (b_ic_idx),
        .oc_idx     (b_oc_idx),
        .layer_done (b_layer_done),
        .err        (b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one cycle of commands at the falling edge; outputs are sampled 1 ns later,
    // where registered outputs reflect the previous cycle's commands.
    task automatic drive(input logic l, input logic cv, input logic tr,
                         input logic co, input logic po, input logic cl);
        @(negedge clk);
        c_load = l;
        conv   = cv;
        tree   = tr;
        cout   = co;
        pool   = po;
        clr    = cl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset_rd_en",      32'(a_rd_en),      0);
        check("reset_rd_addr",    32'(a_rd_addr),    0);
        check("reset_ic_idx",     32'(a_ic_idx),     0);
        check("reset_oc_idx",     32'(a_oc_idx),     0);
        check("reset_layer_done", 32'(a_layer_done), 0);
        check("reset_err",        32'(a_err),        0);
        check("reset_conv_done",  32'(a_conv_done),  0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("c_load_conv_done", 32'(a_conv_done), 0);

        for (int oc = 0; oc < 2; oc++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                check("conv_ic_idx",      32'(a_ic_idx),     32'(k));
                check("conv_oc_idx",      32'(a_oc_idx),     32'(oc));
                check("conv_done_conv",   32'(a_conv_done),  32'(k == 3));
                check("rd_en_low",        32'(a_rd_en),      0);
                check("ic1_conv_done",    32'(b_conv_done),  1);
                check("ic1_ic_idx",       32'(b_ic_idx),     0);
                drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                check("conv_done_tree",   32'(a_conv_done),  32'(k == 3));
                check("rd_en_high",       32'(a_rd_en),      1);
                check("rd_addr",          32'(a_rd_addr),    32'(oc * 4 + k));
                check("ic1_rd_addr",      32'(b_rd_addr),    32'(oc));
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("cout_ic_idx_wrap", 32'(a_ic_idx),    0);
            check("cout_rd_en",       32'(a_rd_en),     0);
            check("cout_done",        32'(a_cout_done), 32'(oc == 1));
        end
        idle();
        check("oc_idx_wrap", 32'(a_oc_idx), 0);

        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("pool_done",       32'(a_pool_done),  32'(p == 2));
            check("layer_done_pool", 32'(a_layer_done), 0);
        end
        idle();
        check("layer_done_pulse", 32'(a_layer_done), 1);
        idle();
        check("layer_done_clear", 32'(a_layer_done), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pool_cnt_restart", 32'(a_pool_done), 0);
        idle();
        check("err_legal_layer", 32'(a_err), 0);

        // Overlapping commands: err must latch and survive idle cycles until clr.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        check("err_set",       32'(a_err),    1);
        check("err_ic_moved",  32'(a_ic_idx), 1);
        idle();
        check("err_sticky",    32'(a_err),    1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_before_clr", 32'(a_err),   1);
        idle();
        check("clr_err",       32'(a_err),    0);
        check("clr_ic_idx",    32'(a_ic_idx), 0);
        check("clr_oc_idx",    32'(a_oc_idx), 0);
        check("clr_rd_en",     32'(a_rd_en),  0);

        // Mid-layer reset after the second tree.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_rd_addr", 32'(a_rd_addr), 1);
        check("pre_rst_ic_idx",  32'(a_ic_idx),  1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd_en",   32'(a_rd_en),   0);
        check("async_rst_rd_addr", 32'(a_rd_addr), 0);
        check("async_rst_ic_idx",  32'(a_ic_idx),  0);
        tree = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("post_rst_rd_en",   32'(a_rd_en),   1);
        check("post_rst_rd_addr", 32'(a_rd_addr), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
